// File: rtl/raster_sequencer.sv
// Raster event sequencer: turns the free-running Pixel/Line counters into a
// frame-start pulse, a frame counter and a lookahead line-render request stream.
module raster_sequencer #(
  parameter int CNT_W     = 10,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int LINE_LEAD = 1,
  parameter int FRAME_W   = 8
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   Pixel,
  input  logic [CNT_W-1:0]   Line,
  input  logic               line_ack,
  output logic               line_req,
  output logic [CNT_W-1:0]   line_num,
  output logic               next_frame,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overrun,
  output logic [7:0]         overrun_cnt
);

  localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_TRIG    = CNT_W'(H_ACTIVE + 1);
  localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_TRIG    = CNT_W'(V_ACTIVE + 1);
  localparam logic [CNT_W:0]   V_LIMIT   = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   LEAD      = (CNT_W+1)'(LINE_LEAD);
  localparam logic [CNT_W:0]   LEAD_LAST = (CNT_W+1)'(LINE_LEAD - 1);

  typedef enum logic [1:0] {IDLE, REQ, PRIME} state_t;

  state_t           state, state_nxt;
  logic             req_nxt;
  logic [CNT_W-1:0] num_nxt;

  logic [CNT_W-1:0] pixel_p1, line_p1;
  logic             line_evt_p0, frame_evt_p0, any_evt_p0, ack_p0;
  logic [CNT_W:0]   target_p0;
  logic             overrun_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One bit wider than the counters so the lookahead sum cannot wrap.
  function automatic logic [CNT_W:0] lead_target(input logic [CNT_W-1:0] l);
    return {1'b0, l} + LEAD;
  endfunction

  // ---- stage p0: edge-qualified event detection on raw counters ----
  assign line_evt_p0  = (Pixel == H_TRIG) && (pixel_p1 == H_END) && (Line < V_END);
  assign frame_evt_p0 = (Line == V_TRIG) && (line_p1 == V_END);
  assign any_evt_p0   = enable && (line_evt_p0 || frame_evt_p0);
  assign ack_p0       = line_req && line_ack;
  assign target_p0    = lead_target(Line);

  always_comb begin
    state_nxt = state;
    req_nxt   = line_req;
    num_nxt   = line_num;
    if (ack_p0) begin
      if (state == PRIME && {1'b0, line_num} < LEAD_LAST) begin
        num_nxt = line_num + CNT_W'(1);
      end else begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    end
    // A new event overrides whatever the ack decided; frame beats line.
    if (enable && frame_evt_p0) begin
      state_nxt = PRIME;
      req_nxt   = 1'b1;
      num_nxt   = '0;
    end else if (enable && line_evt_p0) begin
      if (target_p0 < V_LIMIT) begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
        num_nxt   = target_p0[CNT_W-1:0];
      end else begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    end
  end

  always_comb begin
    overrun_nxt = any_evt_p0 && line_req && !line_ack;
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk100) begin
    if (rst) begin
      state    <= IDLE;
      line_req <= 1'b0;
      line_num <= '0;
    end else begin
      state    <= state_nxt;
      line_req <= req_nxt;
      line_num <= num_nxt;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      pixel_p1    <= '0;
      line_p1     <= '0;
      next_frame  <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      pixel_p1   <= Pixel;
      line_p1    <= Line;
      next_frame <= frame_evt_p0;
      if (frame_evt_p0) frame_cnt <= frame_cnt + FRAME_W'(1);
      overrun <= overrun_nxt;
      if (overrun_nxt) overrun_cnt <= sat_inc(overrun_cnt);
    end
  end

endmodule

// File: tb/tb_raster_sequencer.sv
// Bench for raster_sequencer: two instances (lookahead 1 and 3) share the raster
// inputs; a range-of-lines reference model predicts every output each cycle.
module tb_raster_sequencer;

  logic       clk100 = 1'b0;
  logic       rst, enable;
  logic [9:0] Pixel, Line;
  logic       ack_v [2];
  logic       line_req_a, line_req_b, next_frame_a, next_frame_b;
  logic       overrun_a, overrun_b;
  logic [9:0] line_num_a, line_num_b;
  logic [7:0] frame_cnt_a, frame_cnt_b, overrun_cnt_a, overrun_cnt_b;

  always #5 clk100 = ~clk100;

  raster_sequencer #(.LINE_LEAD(1)) u_a (
    .clk100(clk100), .rst(rst), .enable(enable), .Pixel(Pixel), .Line(Line),
    .line_ack(ack_v[0]), .line_req(line_req_a), .line_num(line_num_a),
    .next_frame(next_frame_a), .frame_cnt(frame_cnt_a), .overrun(overrun_a),
    .overrun_cnt(overrun_cnt_a));

  raster_sequencer #(.LINE_LEAD(3)) u_b (
    .clk100(clk100), .rst(rst), .enable(enable), .Pixel(Pixel), .Line(Line),
    .line_ack(ack_v[1]), .line_req(line_req_b), .line_num(line_num_b),
    .next_frame(next_frame_b), .frame_cnt(frame_cnt_b), .overrun(overrun_b),
    .overrun_cnt(overrun_cnt_b));

  int errors = 0;
  int checks = 0;

  function automatic int lead_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Reference model: pending work is the inclusive line range m_cur..m_last (m_cur<0: none).
  int m_pp, m_lp, m_fc, m_nf;
  int m_cur [2];
  int m_last [2];
  int m_ovr [2];
  int m_ocnt [2];

  always @(posedge clk100) begin
    bit lev, fev, pend, ack, evt;
    if (rst) begin
      m_pp <= 0; m_lp <= 0; m_fc <= 0; m_nf <= 0;
      for (int i = 0; i < 2; i++) begin
        m_cur[i] <= -1; m_last[i] <= -1; m_ovr[i] <= 0; m_ocnt[i] <= 0;
      end
    end else begin
      lev = (int'(Pixel) == 641) && (m_pp == 640) && (int'(Line) < 480);
      fev = (int'(Line) == 481) && (m_lp == 480);
      m_pp <= int'(Pixel);
      m_lp <= int'(Line);
      m_nf <= fev ? 1 : 0;
      if (fev) m_fc <= (m_fc + 1) % 256;
      for (int i = 0; i < 2; i++) begin
        pend = (m_cur[i] >= 0);
        ack  = pend && ack_v[i];
        evt  = enable && (lev || fev);
        m_ovr[i] <= (evt && pend && !ack) ? 1 : 0;
        if (evt && pend && !ack && m_ocnt[i] < 255) m_ocnt[i] <= m_ocnt[i] + 1;
        if (enable && fev) begin
          m_cur[i] <= 0; m_last[i] <= lead_of(i) - 1;
        end else if (enable && lev) begin
          if (int'(Line) + lead_of(i) < 480) begin
            m_cur[i] <= int'(Line) + lead_of(i); m_last[i] <= int'(Line) + lead_of(i);
          end else begin
            m_cur[i] <= -1;
          end
        end else if (ack) begin
          if (m_cur[i] < m_last[i]) m_cur[i] <= m_cur[i] + 1;
          else m_cur[i] <= -1;
        end
      end
    end
  end

  // Renderer stand-in: ack ack_dly cycles after a request becomes visible.
  int  ack_dly [2];
  int  ack_cnt [2];
  bit  ack_noise, ack_rand;
  logic req_v [2];
  logic [9:0] num_v [2];
  assign req_v[0] = line_req_a;
  assign req_v[1] = line_req_b;
  assign num_v[0] = line_num_a;
  assign num_v[1] = line_num_b;

  initial begin
    ack_v[0] = 1'b0; ack_v[1] = 1'b0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
  end

  always @(negedge clk100) begin
    for (int i = 0; i < 2; i++) begin
      if (!req_v[i]) begin
        ack_cnt[i] = 0;
        ack_v[i] = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (ack_v[i]) begin
        ack_v[i] = 1'b0;
        ack_cnt[i] = 0;
        if (ack_rand) ack_dly[i] = $urandom_range(0, 4);
      end else begin
        ack_cnt[i] = ack_cnt[i] + 1;
        if (ack_dly[i] >= 0 && ack_cnt[i] >= ack_dly[i]) ack_v[i] = 1'b1;
      end
    end
  end

  // Event monitor for the directed tests.
  int   req_cnt [2];
  int   ovr_pulses [2];
  int   nf_cnt;
  int   issued0 [$];
  int   issued1 [$];
  logic prev_req [2];
  logic [9:0] prev_num [2];

  always @(negedge clk100) begin
    if (next_frame_a) nf_cnt <= nf_cnt + 1;
    if (overrun_a) ovr_pulses[0] <= ovr_pulses[0] + 1;
    if (overrun_b) ovr_pulses[1] <= ovr_pulses[1] + 1;
    for (int i = 0; i < 2; i++) begin
      if (req_v[i] && (!prev_req[i] || num_v[i] != prev_num[i])) begin
        req_cnt[i] <= req_cnt[i] + 1;
        if (i == 0) issued0.push_back(int'(num_v[i]));
        else issued1.push_back(int'(num_v[i]));
      end
      prev_req[i] <= req_v[i];
      prev_num[i] <= num_v[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic clear_mon();
    #1;
    nf_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      req_cnt[i] = 0; ovr_pulses[i] = 0;
    end
    issued0.delete();
    issued1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; ack_rand = 1'b0; ack_noise = 1'b0;
    Pixel = 10'd0; Line = 10'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic line_pulse(input int l);
    Line = 10'(l);
    Pixel = 10'd639; tick(2);
    Pixel = 10'd640; tick(2);
    Pixel = 10'd641; tick(2);
    Pixel = 10'd642; tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; Pixel = 10'd0; Line = 10'd0;
    ack_dly[0] = 1; ack_dly[1] = 1; ack_noise = 1'b0; ack_rand = 1'b0;
    tick(3); #1;
    checks++; if (line_req_a !== 1'b0) begin errors++; $display("FAIL reset_line_req got %b want 0", line_req_a); end
    checks++; if (line_num_a !== 10'd0) begin errors++; $display("FAIL reset_line_num got %0d want 0", line_num_a); end
    checks++; if (next_frame_a !== 1'b0) begin errors++; $display("FAIL reset_next_frame got %b want 0", next_frame_a); end
    checks++; if (frame_cnt_a !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt_a); end
    checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_a); end
    checks++; if (overrun_cnt_a !== 8'd0) begin errors++; $display("FAIL reset_overrun_cnt got %0d want 0", overrun_cnt_a); end
    checks++; if (line_req_b !== 1'b0) begin errors++; $display("FAIL reset_line_req_b got %b want 0", line_req_b); end
    // Raw trigger values right out of reset must not fire: previous samples are 0.
    Pixel = 10'd641; Line = 10'd481;
    rst = 1'b0;
    tick(2); #1;
    checks++; if (line_req_a !== 1'b0) begin errors++; $display("FAIL post_reset_no_req got %b want 0", line_req_a); end
    checks++; if (frame_cnt_a !== 8'd0) begin errors++; $display("FAIL post_reset_no_frame got %0d want 0", frame_cnt_a); end
  endtask

  task automatic test_line_event();
    do_reset(); clear_mon();
    ack_dly[0] = 3; ack_dly[1] = 3; enable = 1'b1; Line = 10'd5;
    for (int p = 0; p < 800; p++) begin
      Pixel = 10'(p); tick(4);
    end
    tick(10); #1;
    checks++; if (req_cnt[0] != 1) begin errors++; $display("FAIL line_req_count got %0d want 1", req_cnt[0]); end
    checks++; if (issued0.size() < 1 || issued0[0] != 6) begin errors++; $display("FAIL line_num_6 got %0d want 6", (issued0.size() > 0) ? issued0[0] : -1); end
    checks++; if (ovr_pulses[0] != 0) begin errors++; $display("FAIL line_no_overrun got %0d want 0", ovr_pulses[0]); end
    checks++; if (line_req_a !== 1'b0) begin errors++; $display("FAIL line_req_retired got %b want 0", line_req_a); end
    checks++; if (issued1.size() != 1 || issued1[0] != 8) begin errors++; $display("FAIL lead3_line_num got %0d reqs want one req of 8", issued1.size()); end
  endtask

  task automatic test_frame_prime();
    do_reset(); clear_mon();
    ack_dly[0] = 2; ack_dly[1] = 2; enable = 1'b1;
    Pixel = 10'd0; Line = 10'd480; tick(5);
    Line = 10'd481; tick(100); #1;
    checks++; if (nf_cnt != 1) begin errors++; $display("FAIL frame_pulse_count got %0d want 1", nf_cnt); end
    checks++; if (frame_cnt_a !== 8'd1) begin errors++; $display("FAIL frame_cnt got %0d want 1", frame_cnt_a); end
    checks++; if (issued0.size() != 1 || issued0[0] != 0) begin errors++; $display("FAIL prime_lead1 got %0d reqs want one req of 0", issued0.size()); end
    checks++; if (issued1.size() != 3 || issued1[0] != 0 || issued1[1] != 1 || issued1[2] != 2)
      begin errors++; $display("FAIL prime_lead3_seq got %0d reqs want 0,1,2", issued1.size()); end
    checks++; if (line_req_b !== 1'b0) begin errors++; $display("FAIL prime_lead3_idle got %b want 0", line_req_b); end
  endtask

  task automatic test_overrun();
    do_reset(); clear_mon();
    ack_dly[0] = -1; ack_dly[1] = -1; enable = 1'b1;
    line_pulse(10);
    line_pulse(11);
    tick(3); #1;
    checks++; if (ovr_pulses[0] != 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", ovr_pulses[0]); end
    checks++; if (overrun_cnt_a !== 8'd1) begin errors++; $display("FAIL overrun_cnt got %0d want 1", overrun_cnt_a); end
    checks++; if (line_num_a !== 10'd12 || line_req_a !== 1'b1) begin errors++; $display("FAIL overrun_replace got num %0d req %b want 12 1", line_num_a, line_req_a); end
    checks++; if (line_num_b !== 10'd14) begin errors++; $display("FAIL overrun_replace_b got %0d want 14", line_num_b); end
  endtask

  task automatic test_no_request();
    do_reset(); clear_mon();
    ack_dly[0] = 1; ack_dly[1] = 1; enable = 1'b1;
    line_pulse(479);
    tick(4); #1;
    checks++; if (req_cnt[0] != 0 || req_cnt[1] != 0) begin errors++; $display("FAIL last_line_no_req got %0d/%0d want 0/0", req_cnt[0], req_cnt[1]); end
    line_pulse(477);
    tick(4); #1;
    checks++; if (issued0.size() != 1 || issued0[0] != 478 || req_cnt[1] != 0)
      begin errors++; $display("FAIL near_end_lead got %0d/%0d reqs want 1 (478)/0", req_cnt[0], req_cnt[1]); end
    clear_mon();
    enable = 1'b0;
    line_pulse(100);
    Line = 10'd480; tick(3);
    Line = 10'd481; tick(4); #1;
    checks++; if (req_cnt[0] != 0 || req_cnt[1] != 0) begin errors++; $display("FAIL disabled_no_req got %0d/%0d want 0/0", req_cnt[0], req_cnt[1]); end
    checks++; if (frame_cnt_a !== 8'd1 || nf_cnt != 1) begin errors++; $display("FAIL disabled_frame_cnt got %0d pulses %0d want 1 1", frame_cnt_a, nf_cnt); end
    enable = 1'b1;
  endtask

  task automatic test_saturate_and_reset();
    do_reset(); clear_mon();
    ack_dly[0] = -1; ack_dly[1] = -1; enable = 1'b1; Line = 10'd10;
    repeat (301) begin
      Pixel = 10'd640; tick(1);
      Pixel = 10'd641; tick(1);
    end
    Pixel = 10'd0;
    tick(3); #1;
    checks++; if (overrun_cnt_a !== 8'd255) begin errors++; $display("FAIL overrun_sat got %0d want 255", overrun_cnt_a); end
    checks++; if (overrun_cnt_b !== 8'd255) begin errors++; $display("FAIL overrun_sat_b got %0d want 255", overrun_cnt_b); end
    checks++; if (ovr_pulses[0] != 300) begin errors++; $display("FAIL overrun_pulse_total got %0d want 300", ovr_pulses[0]); end
    checks++; if (line_req_a !== 1'b1) begin errors++; $display("FAIL pre_reset_req got %b want 1", line_req_a); end
    @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100); #1;
    checks++; if (line_req_a !== 1'b0 || line_num_a !== 10'd0 || line_req_b !== 1'b0)
      begin errors++; $display("FAIL mid_req_reset got req %b num %0d want 0 0", line_req_a, line_num_a); end
    checks++; if (overrun_cnt_a !== 8'd0 || overrun_a !== 1'b0 || frame_cnt_a !== 8'd0 || next_frame_a !== 1'b0)
      begin errors++; $display("FAIL mid_req_reset_stats got cnt %0d want 0", overrun_cnt_a); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    ack_rand = 1'b1; ack_noise = 1'b1;
    ack_dly[0] = 1; ack_dly[1] = 2;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      #1;
      checks++; if (line_req_a !== (m_cur[0] >= 0)) begin errors++; $display("FAIL rnd_req_a cyc %0d got %b want %0d", c, line_req_a, m_cur[0] >= 0); end
      checks++; if (line_req_b !== (m_cur[1] >= 0)) begin errors++; $display("FAIL rnd_req_b cyc %0d got %b want %0d", c, line_req_b, m_cur[1] >= 0); end
      if (m_cur[0] >= 0) begin
        checks++; if (int'(line_num_a) != m_cur[0]) begin errors++; $display("FAIL rnd_num_a cyc %0d got %0d want %0d", c, line_num_a, m_cur[0]); end
      end
      if (m_cur[1] >= 0) begin
        checks++; if (int'(line_num_b) != m_cur[1]) begin errors++; $display("FAIL rnd_num_b cyc %0d got %0d want %0d", c, line_num_b, m_cur[1]); end
      end
      checks++; if (next_frame_b !== 1'(m_nf) || frame_cnt_b !== 8'(m_fc)) begin errors++; $display("FAIL rnd_frame cyc %0d got %b/%0d want %0d/%0d", c, next_frame_b, frame_cnt_b, m_nf, m_fc); end
      checks++; if (overrun_a !== 1'(m_ovr[0]) || int'(overrun_cnt_a) != m_ocnt[0]) begin errors++; $display("FAIL rnd_ovr_a cyc %0d got %b/%0d want %0d/%0d", c, overrun_a, overrun_cnt_a, m_ovr[0], m_ocnt[0]); end
      checks++; if (overrun_b !== 1'(m_ovr[1]) || int'(overrun_cnt_b) != m_ocnt[1]) begin errors++; $display("FAIL rnd_ovr_b cyc %0d got %b/%0d want %0d/%0d", c, overrun_b, overrun_cnt_b, m_ovr[1], m_ocnt[1]); end
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0: Pixel = 10'd639;
          1, 2: Pixel = 10'd640;
          3, 4: Pixel = 10'd641;
          default: Pixel = 10'($urandom_range(0, 799));
        endcase
        case ($urandom_range(0, 7))
          0: Line = 10'd479;
          1: Line = 10'd480;
          2: Line = 10'd481;
          3, 4: Line = Line;
          default: Line = 10'($urandom_range(0, 524));
        endcase
        enable = ($urandom_range(0, 9) != 0);
        hold = $urandom_range(1, 3);
      end
      hold--;
      @(negedge clk100);
    end
    ack_rand = 1'b0; ack_noise = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; Pixel = 10'd0; Line = 10'd0;
    ack_dly[0] = 1; ack_dly[1] = 1; ack_noise = 1'b0; ack_rand = 1'b0;
    nf_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      req_cnt[i] = 0; ovr_pulses[i] = 0; prev_req[i] = 1'b0; prev_num[i] = 10'd0;
    end
    test_reset();
    test_line_event();
    test_frame_prime();
    test_overrun();
    test_no_request();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raster_sequencer.md
# raster_sequencer

Parametrised raster event sequencer in the clk100 domain. It watches the free-running Pixel/Line counters from the display timing generator. From them it produces a single-cycle frame-start pulse, a frame counter, and a lookahead line-render request stream with a req/ack handshake to the line renderer. Render underruns are detected and counted. It sits between the VGA timing generator and the line-buffer renderer.

## Interface
- CNT_W, 10, width of Pixel/Line/line_num
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- LINE_LEAD, 1, lines of render lookahead (1..4)
- FRAME_W, 8, width of frame_cnt
- clk100  in  1  system clock; Pixel/Line are synchronous to it but may hold a value for many cycles
- rst  in  1  synchronous, active-high reset
- enable  in  1  gates request generation; events ignored while low
- Pixel  in  CNT_W  current horizontal count
- Line  in  CNT_W  current vertical count
- line_ack  in  1  renderer accepts current request
- line_req  out  1  render request valid (level)
- line_num  out  CNT_W  line index requested, stable while line_req high
- next_frame  out  1  one-cycle pulse per frame end
- frame_cnt  out  FRAME_W  frames seen, wraps
- overrun  out  1  one-cycle pulse on request overrun
- overrun_cnt  out  8  saturating overrun count

## Operation
- Pixel_1/Line_1 register the previous samples. Both reset to 0, so no event can fire in the first cycle after reset.
- Line event: Pixel==H_ACTIVE+1 and Pixel_1==H_ACTIVE and Line<V_ACTIVE. Fires once per transition, not per held cycle.
- Frame event: Line==V_ACTIVE+1 and Line_1==V_ACTIVE.
- Frame event (always, regardless of enable): next_frame pulses and frame_cnt increments mod 2^FRAME_W.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: one request outstanding.
  - PRIME: issuing lines 0..LINE_LEAD-1 for the coming frame.
- IDLE + frame event + enable: go to PRIME with line_num=0 and line_req=1.
- IDLE + line event on line L + enable:
  - L+LINE_LEAD<V_ACTIVE: go to REQ with line_num=L+LINE_LEAD.
  - Otherwise: stay IDLE.
- REQ: when line_req && line_ack, drop line_req next cycle and go to IDLE.
- PRIME: on ack of line k:
  - k+1<LINE_LEAD: issue k+1 on the next cycle (line_req stays high, line_num=k+1).
  - Otherwise: go to IDLE.
- Overrun: an enabled event in the same cycle that a request is outstanding and not being acked.
  - overrun pulses and overrun_cnt increments, saturating at 255.
  - The new request replaces the pending one: new line_num, state set as if from IDLE. An aborted PRIME is not resumed.
- Event coincident with ack: no overrun. The ack retires the old request and the new request is issued next cycle.
- Line and frame events cannot coincide by construction. If they do, the frame event wins.
- enable low:
  - Line/frame events create no requests. next_frame and frame_cnt still run.
  - An outstanding request stays up until acked.
- line_ack while line_req is low is ignored.

## Timing
- Registered outputs. Pulses and request assertion appear 1 clk100 after the edge at which the triggering Pixel/Line value is first sampled.
- line_req falls 1 cycle after the edge sampling line_req&&line_ack.
- Back-to-back PRIME requests: line_num advances on the cycle after the ack, with no gap in line_req.
- Reset values: line_req=0, line_num=0, next_frame=0, frame_cnt=0, overrun=0, overrun_cnt=0, state=IDLE.
- Reset mid-request drops line_req on the next cycle. The renderer must discard that request.

## Test plan
- Pixel ramp 0..799 at 4 clk/step, Line=5, LINE_LEAD=1, enable=1, ack 3 cycles after req -> exactly one line_req with line_num=6. No overrun.
- Line steps 480→481, held 100 cycles -> one next_frame pulse, frame_cnt 0→1, PRIME issues line_num 0.
- LINE_LEAD=3 frame event, ack each request after 2 cycles -> line_num sequence 0,1,2, then IDLE.
- Never ack, two line events on lines 10 and 11 -> overrun pulse once, overrun_cnt=1, line_num=12.
- Line event on line 479, LINE_LEAD=1 -> no request. enable=0 on any line -> no request, but frame_cnt still increments.
- 300 forced overruns -> overrun_cnt saturates at 255. rst asserted mid-REQ -> all outputs return to reset values next cycle.
